iir_coeff_loader: RTL and testbench
===================================

// Module: iir_coeff_loader
// PURPOSE
//  Upstream configuration stage for the cascaded IIR filter. It holds a shadow bank and an active bank.
//  The shadow bank (b0,b1,b2,a1,a2,a3,order) is written over a simple register port.
//  On commit, the shadow bank is copied to the active bank only at a sample boundary,
//  so the filter never runs a sample on a mix of old and new coefficients.
//  When order changes, the block pulses a state-clear request that drives the filter's reset input.
// PARAMETERS
//  DW           16  coefficient / write-data width
//  RESET_ORDER  1   order value loaded into both banks at reset (must be 1..3)
//  CLEAR_CYCLES 2   filt_clear high time, in cycles, after an order-changing swap (>=1)
// PORTS
//  clk          in   1     rising-edge clock
//  reset        in   1     synchronous, active-high reset
//  wr_en        in   1     write strobe for the shadow bank
//  wr_addr      in   4     0=b0 1=b1 2=b2 3=a1 4=a2 5=a3 6=order
//  wr_data      in   DW    write data; for addr 6 only bits [3:0] are used
//  wr_err       out  1     1-cycle pulse: the write was rejected
//  rd_addr      in   4     readback address (same map as wr_addr)
//  rd_bank      in   1     readback bank select: 0=shadow, 1=active
//  rd_data      out  DW    registered readback data; order is zero-extended
//  commit       in   1     request a copy from shadow to active
//  sample_tick  in   1     1-cycle pulse marking the cycle the filter accepts a new sample
//  pending      out  1     a commit is waiting for sample_tick
//  swap_done    out  1     1-cycle pulse in the cycle after the active bank updates
//  b0,b1,b2     out  DW    active feed-forward coefficients, registered
//  a1,a2,a3     out  DW    active feedback coefficients, registered
//  order        out  4     active filter order (1..3), registered
//  filt_clear   out  1     filter state-clear request
// BEHAVIOUR
//  Reset:
//   - All coefficients in both banks go to 0; both order registers go to RESET_ORDER.
//   - wr_err, rd_data, pending, swap_done and filt_clear go to 0.
//   - Reset also abandons any pending commit and cancels any in-progress clear.
//  Writes:
//   - A write is accepted when wr_en=1, pending=0, and the address/data are legal.
//   - An accepted write updates the shadow register on the next edge.
//   - wr_err pulses in the cycle after the write and the shadow bank is unchanged when:
//     wr_addr>6; or wr_addr=6 with wr_data[3:0] outside 1..3; or pending=1 (shadow is locked).
//  Readback: rd_data is valid 1 cycle after rd_addr/rd_bank. rd_addr>6 reads 0. No error flag.
//  Commit state machine, IDLE -> ARMED -> IDLE:
//   - IDLE: commit=1 moves to ARMED on the next edge and sets pending=1.
//     A write and a commit in the same cycle: the write lands, then the commit arms.
//   - ARMED: commit=1 is ignored. On sample_tick=1 the active bank takes the shadow bank on that edge,
//     pending drops to 0 and the FSM returns to IDLE. swap_done pulses in the following cycle.
//   - commit and sample_tick in the same cycle while IDLE: the commit only arms.
//     The swap waits for a later tick; a tick that coincides with arming never swaps.
//  Order-change clear:
//   - If a swap changes order, filt_clear goes high on the swap edge and stays high for exactly CLEAR_CYCLES cycles.
//   - A swap that leaves order unchanged does not assert filt_clear.
//   - While filt_clear=1, a new commit may arm but cannot swap. Ticks during the clear are skipped.
//  Outputs: every output is registered. The active-bank outputs change only on a swap edge or on reset.
// TESTING
//  1. Reset, then read active addr 6 -> rd_data=1 one cycle later. All coefficients read 0; pending=0; filt_clear=0.
//  2. Write b0=0x1234, commit, hold sample_tick low 5 cycles -> pending=1, b0 output still 0.
//     Then tick -> b0=0x1234 on that edge, swap_done pulses the next cycle, pending=0.
//  3. Write order=2 then commit, then tick -> order=2 and filt_clear high for exactly 2 cycles.
//     Commit with order unchanged -> no filt_clear.
//  4. Write addr 9, order=0, or order=5 -> wr_err pulse each time and shadow unchanged.
//     Write while pending -> wr_err, and the value never reaches the active bank.
//  5. commit and sample_tick in the same cycle -> no swap. The swap happens on the next tick.
//     Assert reset while pending -> pending=0, active bank back to reset values, and a later tick causes no swap.

Source files
------------

// File: rtl/iir_coeff_loader_if.sv
// Bus bundle for the IIR coefficient loader: shadow-bank register port,
// readback port, commit/sample handshake and the active-bank outputs.
//
// Handshake semantics: wr_en, commit and sample_tick are single-cycle
// strobes sampled on the rising clock edge. The loader has no ready
// signal. A write is taken on the edge where wr_en=1. If it is refused,
// wr_err is high for the one cycle that follows. A commit is taken when
// pending=0. The swap happens on the first later edge where sample_tick=1
// and filt_clear=0. swap_done is high for the one cycle that follows it.
interface iir_coeff_loader_if #(
    parameter int DW = 16
);
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_err;
    logic [3:0]    rd_addr;
    logic          rd_bank;
    logic [DW-1:0] rd_data;
    logic          commit;
    logic          sample_tick;
    logic          pending;
    logic          swap_done;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    logic [DW-1:0] b2;
    logic [DW-1:0] a1;
    logic [DW-1:0] a2;
    logic [DW-1:0] a3;
    logic [3:0]    order;
    logic          filt_clear;
    logic          state_dbg;   // commit FSM state: 0=IDLE, 1=ARMED

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rd_bank, commit, sample_tick,
        input  wr_err, rd_data, pending, swap_done,
        input  b0, b1, b2, a1, a2, a3, order, filt_clear, state_dbg
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rd_bank, commit, sample_tick,
        output wr_err, rd_data, pending, swap_done,
        output b0, b1, b2, a1, a2, a3, order, filt_clear, state_dbg
    );
endinterface

// File: rtl/iir_coeff_loader.sv
// Coefficient loader for the cascaded IIR filter. Writes go to a shadow
// bank. A commit copies the shadow bank to the active bank, but only on a
// sample boundary, so no sample is ever filtered with mixed coefficients.
// A swap that changes the filter order also raises filt_clear for
// CLEAR_CYCLES cycles, which resets the filter state.
module iir_coeff_loader #(
    parameter int DW           = 16,
    parameter int RESET_ORDER  = 1,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    iir_coeff_loader_if.slave bus
);

    localparam logic [3:0] ADDR_B0    = 4'd0;
    localparam logic [3:0] ADDR_B1    = 4'd1;
    localparam logic [3:0] ADDR_B2    = 4'd2;
    localparam logic [3:0] ADDR_A1    = 4'd3;
    localparam logic [3:0] ADDR_A2    = 4'd4;
    localparam logic [3:0] ADDR_A3    = 4'd5;
    localparam logic [3:0] ADDR_ORDER = 4'd6;
    localparam logic [3:0] RST_ORD    = 4'(RESET_ORDER);

    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    // Shadow bank
    logic [DW-1:0] r_sh_b0, r_sh_b1, r_sh_b2;
    logic [DW-1:0] r_sh_a1, r_sh_a2, r_sh_a3;
    logic [3:0]    r_sh_order;

    // Active bank
    logic [DW-1:0] r_ac_b0, r_ac_b1, r_ac_b2;
    logic [DW-1:0] r_ac_a1, r_ac_a2, r_ac_a3;
    logic [3:0]    r_ac_order;

    state_t        r_state;
    logic          r_pending;
    logic          r_swap_done;
    logic          r_filt_clear;
    logic [CW-1:0] r_clr_cnt;
    logic          r_wr_err;
    logic [DW-1:0] r_rd_data;

    logic [3:0]    w_wr_ord;
    logic          w_order_ok;
    logic          w_wr_legal;
    logic          w_wr_accept;
    logic          w_wr_reject;
    logic          w_swap;
    logic          w_order_change;
    logic [DW-1:0] w_rd_shadow;
    logic [DW-1:0] w_rd_active;

    // Write qualification. While a commit is pending the shadow bank is
    // locked, so the bank being copied is the one the user committed.
    assign w_wr_ord    = bus.wr_data[3:0];
    assign w_order_ok  = (w_wr_ord >= 4'd1) && (w_wr_ord <= 4'd3);
    assign w_wr_legal  = (bus.wr_addr <= ADDR_ORDER) &&
                         ((bus.wr_addr != ADDR_ORDER) || w_order_ok);
    assign w_wr_accept = bus.wr_en && !r_pending && w_wr_legal;
    assign w_wr_reject = bus.wr_en && !w_wr_accept;

    // A sample tick is ignored while the filter state is still being
    // cleared. The commit stays armed and waits for a later tick.
    assign w_swap         = (r_state == S_ARMED) && bus.sample_tick && !r_filt_clear;
    assign w_order_change = (r_sh_order != r_ac_order);

    // Shadow-bank write port and the write-error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_b0    <= '0;
            r_sh_b1    <= '0;
            r_sh_b2    <= '0;
            r_sh_a1    <= '0;
            r_sh_a2    <= '0;
            r_sh_a3    <= '0;
            r_sh_order <= RST_ORD;
            r_wr_err   <= 1'b0;
        end else begin
            r_wr_err <= w_wr_reject;
            if (w_wr_accept) begin
                case (bus.wr_addr)
                    ADDR_B0:    r_sh_b0    <= bus.wr_data;
                    ADDR_B1:    r_sh_b1    <= bus.wr_data;
                    ADDR_B2:    r_sh_b2    <= bus.wr_data;
                    ADDR_A1:    r_sh_a1    <= bus.wr_data;
                    ADDR_A2:    r_sh_a2    <= bus.wr_data;
                    ADDR_A3:    r_sh_a3    <= bus.wr_data;
                    ADDR_ORDER: r_sh_order <= w_wr_ord;
                    default:    r_sh_order <= r_sh_order;
                endcase
            end
        end
    end

    // Commit FSM. It also owns the active bank, swap_done and the
    // order-change clear countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pending    <= 1'b0;
            r_swap_done  <= 1'b0;
            r_filt_clear <= 1'b0;
            r_clr_cnt    <= '0;
            r_ac_b0      <= '0;
            r_ac_b1      <= '0;
            r_ac_b2      <= '0;
            r_ac_a1      <= '0;
            r_ac_a2      <= '0;
            r_ac_a3      <= '0;
            r_ac_order   <= RST_ORD;
        end else begin
            r_swap_done <= 1'b0;

            // Count down the clear. A swap cannot start while the clear
            // is high, so this never collides with a new load below.
            if (r_filt_clear) begin
                if (r_clr_cnt == '0) begin
                    r_filt_clear <= 1'b0;
                end else begin
                    r_clr_cnt <= r_clr_cnt - 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    // A tick that arrives in the same cycle as the commit
                    // only arms the FSM. It never swaps.
                    if (bus.commit) begin
                        r_state   <= S_ARMED;
                        r_pending <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_swap) begin
                        r_ac_b0     <= r_sh_b0;
                        r_ac_b1     <= r_sh_b1;
                        r_ac_b2     <= r_sh_b2;
                        r_ac_a1     <= r_sh_a1;
                        r_ac_a2     <= r_sh_a2;
                        r_ac_a3     <= r_sh_a3;
                        r_ac_order  <= r_sh_order;
                        r_state     <= S_IDLE;
                        r_pending   <= 1'b0;
                        r_swap_done <= 1'b1;
                        if (w_order_change) begin
                            r_filt_clear <= 1'b1;
                            r_clr_cnt    <= CLR_LOAD;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    // Readback muxes for the two banks
    always_comb begin
        w_rd_shadow = '0;
        w_rd_active = '0;
        case (bus.rd_addr)
            ADDR_B0: begin
                w_rd_shadow = r_sh_b0;
                w_rd_active = r_ac_b0;
            end
            ADDR_B1: begin
                w_rd_shadow = r_sh_b1;
                w_rd_active = r_ac_b1;
            end
            ADDR_B2: begin
                w_rd_shadow = r_sh_b2;
                w_rd_active = r_ac_b2;
            end
            ADDR_A1: begin
                w_rd_shadow = r_sh_a1;
                w_rd_active = r_ac_a1;
            end
            ADDR_A2: begin
                w_rd_shadow = r_sh_a2;
                w_rd_active = r_ac_a2;
            end
            ADDR_A3: begin
                w_rd_shadow = r_sh_a3;
                w_rd_active = r_ac_a3;
            end
            ADDR_ORDER: begin
                w_rd_shadow = DW'(r_sh_order);
                w_rd_active = DW'(r_ac_order);
            end
            default: begin
                w_rd_shadow = '0;
                w_rd_active = '0;
            end
        endcase
    end

    // Registered readback. Unmapped addresses read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= bus.rd_bank ? w_rd_active : w_rd_shadow;
        end
    end

    assign bus.wr_err     = r_wr_err;
    assign bus.rd_data    = r_rd_data;
    assign bus.pending    = r_pending;
    assign bus.swap_done  = r_swap_done;
    assign bus.filt_clear = r_filt_clear;
    assign bus.b0         = r_ac_b0;
    assign bus.b1         = r_ac_b1;
    assign bus.b2         = r_ac_b2;
    assign bus.a1         = r_ac_a1;
    assign bus.a2         = r_ac_a2;
    assign bus.a3         = r_ac_a3;
    assign bus.order      = r_ac_order;
    assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Bench for iir_coeff_loader. It runs a directed sequence with literal
// expectations, then a long randomized phase. A behavioural model of the
// two banks is compared against every output on every cycle.
module tb_iir_coeff_loader;

    localparam int DW           = 16;
    localparam int CLEAR_CYCLES = 2;

    logic clk;
    logic reset;

    iir_coeff_loader_if #(.DW(DW)) bus();

    iir_coeff_loader #(
        .DW(DW),
        .RESET_ORDER(1),
        .CLEAR_CYCLES(CLEAR_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int  n_total = 0;
    int  n_pass  = 0;
    bit  chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Bank entries are indexed by register address; entry 6 is the order.
    logic [DW-1:0] m_sh[0:6];
    logic [DW-1:0] m_ac[0:6];
    bit            m_pend;
    int            m_clr;          // cycles of filt_clear still to show
    logic          m_wr_err;
    logic          m_swap_done;
    logic [DW-1:0] m_rd;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                m_sh[i] = '0;
                m_ac[i] = '0;
            end
            m_sh[6]     = 16'd1;
            m_ac[6]     = 16'd1;
            m_pend      = 1'b0;
            m_clr       = 0;
            m_wr_err    = 1'b0;
            m_swap_done = 1'b0;
            m_rd        = '0;
        end else begin : model_step
            bit            bad;
            bit            do_swap;
            bit            arm;
            int            a;
            int            ra;
            logic [DW-1:0] d;
            a  = int'(bus.wr_addr);
            ra = int'(bus.rd_addr);
            d  = bus.wr_data;
            bad = (a > 6) || (a == 6 && (d[3:0] < 4'd1 || d[3:0] > 4'd3)) || m_pend;
            m_wr_err = bus.wr_en && bad;
            if (ra > 6) m_rd = '0;
            else if (bus.rd_bank) m_rd = m_ac[ra];
            else m_rd = m_sh[ra];
            do_swap = m_pend && bus.sample_tick && (m_clr == 0);
            arm     = !m_pend && bus.commit;
            if (m_clr > 0) m_clr--;
            if (do_swap) begin
                if (m_sh[6] != m_ac[6]) m_clr = CLEAR_CYCLES;
                for (int i = 0; i < 7; i++) m_ac[i] = m_sh[i];
            end
            m_swap_done = do_swap;
            if (bus.wr_en && !bad) m_sh[a] = (a == 6) ? {12'd0, d[3:0]} : d;
            if (arm) m_pend = 1'b1;
            else if (do_swap) m_pend = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_err",     32'(bus.wr_err),     32'(m_wr_err));
            check("rd_data",    32'(bus.rd_data),    32'(m_rd));
            check("pending",    32'(bus.pending),    32'(m_pend));
            check("state_dbg",  32'(bus.state_dbg),  32'(m_pend));
            check("swap_done",  32'(bus.swap_done),  32'(m_swap_done));
            check("filt_clear", 32'(bus.filt_clear), 32'(m_clr > 0));
            check("b0",         32'(bus.b0),         32'(m_ac[0]));
            check("b1",         32'(bus.b1),         32'(m_ac[1]));
            check("b2",         32'(bus.b2),         32'(m_ac[2]));
            check("a1",         32'(bus.a1),         32'(m_ac[3]));
            check("a2",         32'(bus.a2),         32'(m_ac[4]));
            check("a3",         32'(bus.a3),         32'(m_ac[5]));
            check("order",      32'(bus.order),      32'(m_ac[6][3:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
    endtask

    task automatic do_tick();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.rd_addr     = '0;
        bus.rd_bank     = 1'b0;
        bus.commit      = 1'b0;
        bus.sample_tick = 1'b0;
        reset           = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        // 1. reset values and active-bank readback
        bus.rd_bank = 1'b1;
        bus.rd_addr = 4'd6;
        step();
        check("lit_rst_order_rd", 32'(bus.rd_data), 32'd1);
        check("lit_rst_pending", 32'(bus.pending), 32'd0);
        check("lit_rst_clear", 32'(bus.filt_clear), 32'd0);
        for (int i = 0; i < 6; i++) begin
            bus.rd_addr = 4'(i);
            step();
            check("lit_rst_coef_rd", 32'(bus.rd_data), 32'd0);
        end

        // 2. commit waits for the tick
        do_write(4'd0, 16'h1234);
        do_commit();
        check("lit_armed_pending", 32'(bus.pending), 32'd1);
        repeat (5) step();
        check("lit_hold_pending", 32'(bus.pending), 32'd1);
        check("lit_hold_b0", 32'(bus.b0), 32'd0);
        do_tick();
        check("lit_swap_b0", 32'(bus.b0), 32'h1234);
        check("lit_model_b0", 32'(m_ac[0]), 32'h1234);
        check("lit_swap_done", 32'(bus.swap_done), 32'd1);
        check("lit_swap_pending", 32'(bus.pending), 32'd0);
        step();
        check("lit_swap_done_end", 32'(bus.swap_done), 32'd0);

        // 3. order change raises filt_clear for exactly two cycles
        do_write(4'd6, 16'd2);
        do_commit();
        do_tick();
        check("lit_order2", 32'(bus.order), 32'd2);
        check("lit_clear_c1", 32'(bus.filt_clear), 32'd1);
        step();
        check("lit_clear_c2", 32'(bus.filt_clear), 32'd1);
        step();
        check("lit_clear_off", 32'(bus.filt_clear), 32'd0);
        do_commit();
        do_tick();
        check("lit_same_order_done", 32'(bus.swap_done), 32'd1);
        check("lit_same_order_noclr", 32'(bus.filt_clear), 32'd0);

        // 4. rejected writes
        do_write(4'd9, 16'h00AA);
        check("lit_err_addr9", 32'(bus.wr_err), 32'd1);
        do_write(4'd6, 16'd0);
        check("lit_err_order0", 32'(bus.wr_err), 32'd1);
        do_write(4'd6, 16'd5);
        check("lit_err_order5", 32'(bus.wr_err), 32'd1);
        bus.rd_bank = 1'b0;
        bus.rd_addr = 4'd6;
        step();
        check("lit_shadow_order", 32'(bus.rd_data), 32'd2);
        check("lit_err_gone", 32'(bus.wr_err), 32'd0);
        do_commit();
        do_write(4'd1, 16'hBEEF);
        check("lit_err_pending", 32'(bus.wr_err), 32'd1);
        do_tick();
        check("lit_locked_b1", 32'(bus.b1), 32'd0);

        // 5. commit with a tick in the same cycle only arms
        do_write(4'd2, 16'h55AA);
        bus.commit      = 1'b1;
        bus.sample_tick = 1'b1;
        step();
        bus.commit      = 1'b0;
        bus.sample_tick = 1'b0;
        check("lit_cotick_pending", 32'(bus.pending), 32'd1);
        check("lit_cotick_b2", 32'(bus.b2), 32'd0);
        check("lit_cotick_nodone", 32'(bus.swap_done), 32'd0);
        do_tick();
        check("lit_late_b2", 32'(bus.b2), 32'h55AA);

        // reset while pending drops the commit
        do_write(4'd3, 16'h0777);
        do_commit();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("lit_rstpend_pending", 32'(bus.pending), 32'd0);
        check("lit_rstpend_b0", 32'(bus.b0), 32'd0);
        check("lit_rstpend_order", 32'(bus.order), 32'd1);
        do_tick();
        check("lit_rstpend_nodone", 32'(bus.swap_done), 32'd0);
        check("lit_rstpend_a1", 32'(bus.a1), 32'd0);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            bus.wr_en       = 1'($urandom_range(0, 1));
            bus.wr_addr     = 4'($urandom_range(0, 9));
            bus.wr_data     = (bus.wr_addr == 4'd6) ? 16'($urandom_range(0, 5)) : 16'($urandom);
            bus.commit      = ($urandom_range(0, 4) == 0);
            bus.sample_tick = ($urandom_range(0, 3) == 0);
            bus.rd_addr     = 4'($urandom_range(0, 8));
            bus.rd_bank     = 1'($urandom_range(0, 1));
            reset           = ($urandom_range(0, 199) == 0);
            step();
        end
        reset           = 1'b0;
        bus.wr_en       = 1'b0;
        bus.commit      = 1'b0;
        bus.sample_tick = 1'b0;
        step();
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
